// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side SRAM-like buses.
package cpu_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [3:0] STRB_NONE = 4'h0;
    localparam logic [3:0] STRB_WORD = 4'hF;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants taken while a fetch request is waiting.
module arb_starve_cnt #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    input  logic pending,
    output logic at_limit
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // Any cycle without a waiting fetch restarts the count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr || !pending) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_W'(LIMIT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_limit = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one single-port synchronous SRAM between the CPU fetch and data ports.
module cpu_sram_arbiter #(
    parameter int unsigned ADDR_W       = cpu_bus_pkg::ADDR_W,
    parameter int unsigned DATA_W       = cpu_bus_pkg::DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    import cpu_bus_pkg::*;

    logic   grant_data;
    logic   grant_inst;
    logic   at_limit;
    logic   resp_valid;
    owner_e resp_owner;

    // Data has priority unless fetch has been passed over too often; nothing is granted in reset.
    always_comb begin
        grant_data = resetn && data_req && !(inst_req && at_limit);
        grant_inst = resetn && inst_req && !grant_data;
    end

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (grant_data && inst_req),
        .clr      (grant_inst),
        .pending  (inst_req),
        .at_limit (at_limit)
    );

    // SRAM issue mux, same cycle as the grant.
    always_comb begin
        sram_en    = grant_data || grant_inst;
        sram_we    = (grant_data && data_wr) ? data_wstrb : STRB_NONE;
        sram_addr  = grant_data ? data_addr : inst_addr;
        sram_wdata = data_wdata;
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // Records who owns the SRAM read data returning next cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_valid <= 1'b0;
            resp_owner <= OWN_INST;
        end else begin
            resp_valid <= grant_data || grant_inst;
            if (grant_data) begin
                resp_owner <= OWN_DATA;
            end else if (grant_inst) begin
                resp_owner <= OWN_INST;
            end
        end
    end

    assign inst_data_ok = resp_valid && (resp_owner == OWN_INST);
    assign data_data_ok = resp_valid && (resp_owner == OWN_DATA);
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed testbench for cpu_sram_arbiter with a behavioural single-port SRAM.
module tb_cpu_sram_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] mem [256];

    int checks;
    int errors;

    cpu_sram_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-indexed SRAM, read data valid the cycle after the enable.
    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= mem[sram_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (sram_we[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
        end
    end

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wr    = dw;
        data_wstrb = ds;
        data_addr  = da;
        data_wdata = dd;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1C000000, 1'b1, 1'b1, 4'hF, 32'h10, 32'h1);
            checks++;
            if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we} !== 9'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b required 0", i,
                         {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we});
            end
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        inst_req = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst_data_ok, data_data_ok, sram_en} !== 3'b0) begin
            errors++;
            $display("FAIL reset_release: got %b required 000", {inst_data_ok, data_data_ok, sram_en});
        end
    endtask

    task automatic test_inst_only();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            checks++;
            if ({inst_addr_ok, sram_en, sram_we} !== 6'b110000 || sram_addr !== 32'h1C000000) begin
                errors++;
                $display("FAIL inst_issue cycle %0d: got ok/en/we=%b addr=%h required 110000 1c000000",
                         i, {inst_addr_ok, sram_en, sram_we}, sram_addr);
            end
            checks++;
            if (inst_data_ok !== (i != 0) || (i != 0 && inst_rdata !== 32'h02800401)) begin
                errors++;
                $display("FAIL inst_resp cycle %0d: got ok=%b data=%h required ok=%b data=02800401",
                         i, inst_data_ok, inst_rdata, (i != 0));
            end
        end
        idle();
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h02800401 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL inst_last_resp: got ok=%b aok=%b data=%h required 1 0 02800401",
                     inst_data_ok, inst_addr_ok, inst_rdata);
        end
        idle();
        checks++;
        if (inst_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL inst_resp_end: got %b required 0", inst_data_ok);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 32'h1C000000, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10 || sram_addr !== 32'h10) begin
            errors++;
            $display("FAIL simul_grant: got d/i=%b addr=%h required 10 00000010",
                     {data_addr_ok, inst_addr_ok}, sram_addr);
        end
        drive(1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'hDEADBEEF || inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL simul_data_resp: got dok=%b data=%h iaok=%b idok=%b required 1 deadbeef 1 0",
                     data_data_ok, data_rdata, inst_addr_ok, inst_data_ok);
        end
        idle();
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h02800401 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL simul_inst_resp: got iok=%b data=%h dok=%b required 1 02800401 0",
                     inst_data_ok, inst_rdata, data_data_ok);
        end
    endtask

    task automatic test_write_read();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h12345678);
        checks++;
        if (data_addr_ok !== 1'b1 || sram_we !== 4'b0011 || sram_wdata !== 32'h12345678 || sram_addr !== 32'h20) begin
            errors++;
            $display("FAIL write_issue: got aok=%b we=%b wdata=%h addr=%h required 1 0011 12345678 00000020",
                     data_addr_ok, sram_we, sram_wdata, sram_addr);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        checks++;
        if (data_data_ok !== 1'b1 || sram_we !== 4'b0000 || sram_en !== 1'b1) begin
            errors++;
            $display("FAIL write_resp: got dok=%b we=%b en=%b required 1 0000 1", data_data_ok, sram_we, sram_en);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1, cpu_bus_pkg::STRB_NONE, 32'h20, 32'hFFFFFFFF);
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'hAABB5678) begin
            errors++;
            $display("FAIL read_after_write: got dok=%b data=%h required 1 aabb5678", data_data_ok, data_rdata);
        end
        checks++;
        if (sram_en !== 1'b1 || sram_we !== 4'b0000 || data_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL zero_strb_issue: got en=%b we=%b aok=%b required 1 0000 1", sram_en, sram_we, data_addr_ok);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        checks++;
        if (data_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL zero_strb_resp: got %b required 1", data_data_ok);
        end
        idle();
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'hAABB5678) begin
            errors++;
            $display("FAIL zero_strb_unchanged: got dok=%b data=%h required 1 aabb5678", data_data_ok, data_rdata);
        end
        idle();
    endtask

    task automatic test_starvation();
        logic exp_inst;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'h1C000000, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
            exp_inst = (i == 5) || (i == 10);
            checks++;
            if (inst_addr_ok !== exp_inst || data_addr_ok !== !exp_inst) begin
                errors++;
                $display("FAIL starve_grant cycle %0d: got i/d=%b%b required %b%b",
                         i, inst_addr_ok, data_addr_ok, exp_inst, !exp_inst);
            end
        end
        idle();
        idle();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL midrst_grant: got %b required 1", inst_addr_ok);
        end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we} !== 9'b0) begin
            errors++;
            $display("FAIL midrst_dropped: got %b required 0",
                     {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we});
        end
        drive(1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL midrst_regrant: got aok=%b dok=%b required 1 0", inst_addr_ok, inst_data_ok);
        end
        idle();
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h02800401) begin
            errors++;
            $display("FAIL midrst_resp: got ok=%b data=%h required 1 02800401", inst_data_ok, inst_rdata);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_inst_grant: got %b required 1", inst_addr_ok);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        checks++;
        if ({data_addr_ok, inst_data_ok, data_data_ok} !== 3'b110 || inst_rdata !== 32'h02800401) begin
            errors++;
            $display("FAIL b2b_resp1: got daok/idok/ddok=%b data=%h required 110 02800401",
                     {data_addr_ok, inst_data_ok, data_data_ok}, inst_rdata);
        end
        drive(1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checks++;
        if ({inst_addr_ok, inst_data_ok, data_data_ok} !== 3'b101 || data_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL b2b_resp2: got iaok/idok/ddok=%b data=%h required 101 deadbeef",
                     {inst_addr_ok, inst_data_ok, data_data_ok}, data_rdata);
        end
        idle();
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h02800401) begin
            errors++;
            $display("FAIL b2b_resp3: got idok/ddok=%b data=%h required 10 02800401",
                     {inst_data_ok, data_data_ok}, inst_rdata);
        end
        idle();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = '0;
        data_addr  = '0;
        data_wdata = '0;
        sram_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h02800401;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'hAABBCCDD;

        test_reset();
        test_inst_only();
        test_simultaneous();
        test_write_read();
        test_starvation();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
